// File: rtl/cpu_instr_sequencer.sv
// cpu_instr_sequencer
// Holds a small loadable program RAM and steps through it one instruction at a
// time: fetch, issue to the cpu, wait a fixed cpu latency, capture the result
// tagged with its program index, then advance. A HALT_OP entry or the last RAM
// entry ends the run.
// Optional feature macro: SEQ_STEP_EN adds iSTEP_MODE/iSTEP and a PAUSE state
// so a run can be single-stepped one instruction at a time.
module cpu_instr_sequencer #(
    parameter int unsigned PROG_DEPTH = 16,
    parameter int unsigned ADDR_W     = 4,
    parameter int unsigned CPU_LAT    = 2,
    parameter logic [7:0]  HALT_OP    = 8'hFF
) (
    input  logic              iCLK,
    input  logic              iRESET,
    input  logic              iLOAD_WE,
    input  logic [ADDR_W-1:0] iLOAD_ADDR,
    input  logic [7:0]        iLOAD_DATA,
    input  logic              iSTART,
    input  logic              iABORT,
    output logic [7:0]        oCPU_INSTR,
    output logic              oCPU_ISSUE,
    input  logic [7:0]        iCPU_RESULT,
    output logic [7:0]        oRESULT,
    output logic              oRESULT_VALID,
    output logic [ADDR_W-1:0] oRESULT_PC,
    output logic [ADDR_W-1:0] oPC,
    output logic              oBUSY,
`ifdef SEQ_STEP_EN
    input  logic              iSTEP_MODE,
    input  logic              iSTEP,
`endif
    output logic              oDONE
);

    // Wait counter only ever holds CPU_LAT-1 down to 1.
    localparam int unsigned CNT_W = (CPU_LAT > 1) ? $clog2(CPU_LAT) : 1;
    localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(PROG_DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FETCH,
        S_ISSUE,
        S_WAIT,
        S_CAPTURE,
        S_DONE
`ifdef SEQ_STEP_EN
        ,
        S_PAUSE
`endif
    } state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        instr_q, instr_d;
    logic [7:0]        result_q, result_d;
    logic [ADDR_W-1:0] rpc_q, rpc_d;
    logic              rvalid_q, rvalid_d;
    logic [7:0]        fetch_q;
    logic              issue;
    logic              done;

    logic [7:0] mem [PROG_DEPTH];

    // Program RAM: writes accepted only while idle; registered read in FETCH.
    always_ff @(posedge iCLK) begin
        if (iLOAD_WE && (state_q == S_IDLE)) begin
            mem[iLOAD_ADDR] <= iLOAD_DATA;
        end
        if (state_q == S_FETCH) begin
            fetch_q <= mem[pc_q];
        end
    end

    // State and datapath registers.
    always_ff @(posedge iCLK or posedge iRESET) begin
        if (iRESET) begin
            state_q  <= S_IDLE;
            pc_q     <= '0;
            cnt_q    <= '0;
            instr_q  <= '0;
            result_q <= '0;
            rpc_q    <= '0;
            rvalid_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            cnt_q    <= cnt_d;
            instr_q  <= instr_d;
            result_q <= result_d;
            rpc_q    <= rpc_d;
            rvalid_q <= rvalid_d;
        end
    end

    // Next-state logic; abort overrides every transition outside IDLE.
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        cnt_d    = cnt_q;
        instr_d  = instr_q;
        result_d = result_q;
        rpc_d    = rpc_q;
        rvalid_d = 1'b0;
        issue    = 1'b0;
        done     = 1'b0;

        if (iABORT && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (iSTART) begin
                        state_d = S_FETCH;
                        pc_d    = '0;
                    end
                end
                S_FETCH: begin
                    state_d = S_ISSUE;
                end
                S_ISSUE: begin
                    if (fetch_q == HALT_OP) begin
                        state_d = S_DONE;
                    end else begin
                        instr_d = fetch_q;
                        issue   = 1'b1;
                        cnt_d   = CNT_W'(CPU_LAT - 1);
                        state_d = (CPU_LAT == 1) ? S_CAPTURE : S_WAIT;
                    end
                end
                S_WAIT: begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = S_CAPTURE;
                    end
                end
                S_CAPTURE: begin
                    result_d = iCPU_RESULT;
                    rpc_d    = pc_q;
                    rvalid_d = 1'b1;
                    if (pc_q == LAST_PC) begin
                        state_d = S_DONE;
`ifdef SEQ_STEP_EN
                    end else if (iSTEP_MODE) begin
                        state_d = S_PAUSE;
`endif
                    end else begin
                        pc_d    = pc_q + ADDR_W'(1);
                        state_d = S_FETCH;
                    end
                end
                S_DONE: begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end
`ifdef SEQ_STEP_EN
                S_PAUSE: begin
                    if (iSTEP) begin
                        pc_d    = pc_q + ADDR_W'(1);
                        state_d = S_FETCH;
                    end
                end
`endif
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign oCPU_INSTR    = instr_q;
    assign oCPU_ISSUE    = issue;
    assign oRESULT       = result_q;
    assign oRESULT_VALID = rvalid_q;
    assign oRESULT_PC    = rpc_q;
    assign oPC           = pc_q;
    assign oBUSY         = (state_q != S_IDLE);
    assign oDONE         = done;

endmodule

// File: tb/tb_cpu_instr_sequencer.sv
// Bench for cpu_instr_sequencer: directed and randomized programs, a cpu model
// (result = instr+1, latency 2) and a program-level reference of the expected
// result stream, issue stream and completion timing.
module tb_cpu_instr_sequencer;

    localparam int DEPTH = 16;
    localparam int AW    = 4;
    localparam int LAT   = 2;
    localparam int P     = LAT + 2;

    logic          clk = 1'b0;
    logic          iRESET = 1'b1;
    logic          iLOAD_WE = 1'b0;
    logic [AW-1:0] iLOAD_ADDR = '0;
    logic [7:0]    iLOAD_DATA = '0;
    logic          iSTART = 1'b0;
    logic          iABORT = 1'b0;
    logic [7:0]    oCPU_INSTR;
    logic          oCPU_ISSUE;
    logic [7:0]    iCPU_RESULT = '0;
    logic [7:0]    oRESULT;
    logic          oRESULT_VALID;
    logic [AW-1:0] oRESULT_PC;
    logic [AW-1:0] oPC;
    logic          oBUSY;
    logic          oDONE;
`ifdef SEQ_STEP_EN
    logic          iSTEP_MODE = 1'b0;
    logic          iSTEP = 1'b0;
`endif

    cpu_instr_sequencer #(
        .PROG_DEPTH(DEPTH),
        .ADDR_W    (AW),
        .CPU_LAT   (LAT),
        .HALT_OP   (8'hFF)
    ) dut (
        .iCLK         (clk),
        .iRESET       (iRESET),
        .iLOAD_WE     (iLOAD_WE),
        .iLOAD_ADDR   (iLOAD_ADDR),
        .iLOAD_DATA   (iLOAD_DATA),
        .iSTART       (iSTART),
        .iABORT       (iABORT),
        .oCPU_INSTR   (oCPU_INSTR),
        .oCPU_ISSUE   (oCPU_ISSUE),
        .iCPU_RESULT  (iCPU_RESULT),
        .oRESULT      (oRESULT),
        .oRESULT_VALID(oRESULT_VALID),
        .oRESULT_PC   (oRESULT_PC),
        .oPC          (oPC),
        .oBUSY        (oBUSY),
`ifdef SEQ_STEP_EN
        .iSTEP_MODE   (iSTEP_MODE),
        .iSTEP        (iSTEP),
`endif
        .oDONE        (oDONE)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int tests = 0;
    int fails = 0;

    logic [7:0] model_mem [DEPTH];
    int v_cyc[$];
    int v_pc[$];
    int v_res[$];
    int i_cyc[$];
    int i_instr[$];
    int d_cnt = 0;
    int d_cyc = 0;
    bit iss_d1 = 1'b0;
    bit iss_d2 = 1'b0;
    int c0 = 0;

    // Observe outputs mid-cycle and play the cpu: the result for an
    // instruction is valid only in the cycle LAT after its issue strobe.
    always @(negedge clk) begin
        if (oRESULT_VALID) begin
            v_cyc.push_back(cyc);
            v_pc.push_back(int'(oRESULT_PC));
            v_res.push_back(int'(oRESULT));
        end
        if (iss_d1) i_instr.push_back(int'(oCPU_INSTR));
        if (oCPU_ISSUE) i_cyc.push_back(cyc);
        if (oDONE) begin
            d_cnt = d_cnt + 1;
            d_cyc = cyc;
        end
        if (iss_d2) iCPU_RESULT = oCPU_INSTR + 8'd1;
        else        iCPU_RESULT = 8'($urandom);
        iss_d2 = iss_d1;
        iss_d1 = oCPU_ISSUE;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_mem(input int a, input logic [7:0] d);
        iLOAD_WE   = 1'b1;
        iLOAD_ADDR = AW'(a);
        iLOAD_DATA = d;
        model_mem[a] = d;
        step();
        iLOAD_WE = 1'b0;
    endtask

    function automatic logic [7:0] gen();
        if ($urandom_range(0, 7) == 0) return 8'hFF;
        return 8'($urandom_range(0, 254));
    endfunction

    task automatic clear_mon();
        v_cyc.delete();
        v_pc.delete();
        v_res.delete();
        i_cyc.delete();
        i_instr.delete();
        d_cnt = 0;
    endtask

    // Pulse start (optionally with a RAM write in the same cycle).
    task automatic start_run(input bit with_wr, input int a, input logic [7:0] d);
        clear_mon();
        c0 = cyc;
        iSTART = 1'b1;
        if (with_wr) begin
            iLOAD_WE   = 1'b1;
            iLOAD_ADDR = AW'(a);
            iLOAD_DATA = d;
            model_mem[a] = d;
        end
        step();
        iSTART   = 1'b0;
        iLOAD_WE = 1'b0;
    endtask

    // Wait for completion and compare against the program-level model:
    // instruction k issues at c0+2+P*k, its result shows at c0+1+P*(k+1).
    task automatic finish_run(input string tag);
        int n;
        bit halted;
        int limit;
        limit = c0 + 1 + P * DEPTH + 10;
        while (d_cnt == 0 && cyc < limit) step();
        check({tag, ".done_seen"}, d_cnt, 1);
        check({tag, ".busy_after"}, oBUSY, 0);
        n = 0;
        while (n < DEPTH && model_mem[n] != 8'hFF) n++;
        halted = (n < DEPTH);
        check({tag, ".n_valid"}, v_res.size(), n);
        for (int k = 0; k < n && k < v_res.size(); k++) begin
            check($sformatf("%s.v%0d_cyc", tag, k), v_cyc[k], c0 + 1 + P * (k + 1));
            check($sformatf("%s.v%0d_pc", tag, k), v_pc[k], k);
            check($sformatf("%s.v%0d_res", tag, k), v_res[k], (int'(model_mem[k]) + 1) % 256);
        end
        check({tag, ".n_issue"}, i_cyc.size(), n);
        for (int k = 0; k < n && k < i_cyc.size() && k < i_instr.size(); k++) begin
            check($sformatf("%s.i%0d_cyc", tag, k), i_cyc[k], c0 + 2 + P * k);
            check($sformatf("%s.i%0d_instr", tag, k), i_instr[k], int'(model_mem[k]));
        end
        check({tag, ".done_cyc"}, d_cyc, halted ? (c0 + 3 + P * n) : (c0 + 1 + P * DEPTH));
        check({tag, ".pc_final"}, oPC, halted ? n : DEPTH - 1);
    endtask

    task automatic load_t1();
        write_mem(0, 8'h11);
        write_mem(1, 8'h22);
        write_mem(2, 8'hFF);
    endtask

    initial begin
        repeat (3) step();
        check("rst.busy", oBUSY, 0);
        check("rst.pc", oPC, 0);
        check("rst.instr", oCPU_INSTR, 0);
        check("rst.issue", oCPU_ISSUE, 0);
        check("rst.result", oRESULT, 0);
        check("rst.rvalid", oRESULT_VALID, 0);
        check("rst.rpc", oRESULT_PC, 0);
        check("rst.done", oDONE, 0);
        iRESET = 1'b0;
        step();

        // 1: short program ending on HALT
        load_t1();
        start_run(1'b0, 0, 8'h00);
        finish_run("t1");

        // 2: full RAM, no HALT
        for (int a = 0; a < DEPTH; a++) write_mem(a, 8'(a * 3 + 1));
        start_run(1'b0, 0, 8'h00);
        finish_run("t2");

        // 3: abort during WAIT of pc1, then rerun
        load_t1();
        start_run(1'b0, 0, 8'h00);
        repeat (6) step();
        check("t3.busy_pre", oBUSY, 1);
        check("t3.pc_pre", oPC, 1);
        iABORT = 1'b1;
        step();
        iABORT = 1'b0;
        check("t3.busy_post", oBUSY, 0);
        check("t3.done_post", oDONE, 0);
        check("t3.rvalid_post", oRESULT_VALID, 0);
        check("t3.instr_held", oCPU_INSTR, 8'h22);
        repeat (10) step();
        check("t3.n_valid", v_res.size(), 1);
        check("t3.n_done", d_cnt, 0);
        check("t3.n_issue", i_cyc.size(), 2);
        start_run(1'b0, 0, 8'h00);
        finish_run("t3r");

        // abort while idle is ignored
        iABORT = 1'b1;
        step();
        iABORT = 1'b0;
        check("idle_abort.busy", oBUSY, 0);

        // 4: write and restart while busy are dropped
        start_run(1'b0, 0, 8'h00);
        iLOAD_WE   = 1'b1;
        iLOAD_ADDR = '0;
        iLOAD_DATA = 8'h55;
        iSTART     = 1'b1;
        step();
        iLOAD_WE = 1'b0;
        iSTART   = 1'b0;
        finish_run("t4a");
        start_run(1'b0, 0, 8'h00);
        finish_run("t4b");

        // 5: async reset in WAIT of pc1
        start_run(1'b0, 0, 8'h00);
        repeat (6) step();
        check("t5.instr_pre", oCPU_INSTR, 8'h22);
        #2 iRESET = 1'b1;
        #1;
        check("t5.busy", oBUSY, 0);
        check("t5.pc", oPC, 0);
        check("t5.instr", oCPU_INSTR, 0);
        check("t5.result", oRESULT, 0);
        check("t5.rpc", oRESULT_PC, 0);
        check("t5.rvalid", oRESULT_VALID, 0);
        step();
        iRESET = 1'b0;
        repeat (6) step();
        check("t5.busy_after", oBUSY, 0);
        check("t5.n_valid", v_res.size(), 1);
        check("t5.n_done", d_cnt, 0);
        start_run(1'b0, 0, 8'h00);
        finish_run("t5r");

        // randomized programs; odd runs write entry 0 together with start
        for (int it = 0; it < 6; it++) begin
            for (int a = 1; a < DEPTH; a++) write_mem(a, gen());
            if (it % 2 == 1) begin
                start_run(1'b1, 0, gen());
            end else begin
                write_mem(0, gen());
                start_run(1'b0, 0, 8'h00);
            end
            finish_run($sformatf("rand%0d", it));
        end

`ifdef SEQ_STEP_EN
        // 6: single-step mode
        load_t1();
        iSTEP_MODE = 1'b1;
        start_run(1'b0, 0, 8'h00);
        for (int w = 0; w < 40 && v_res.size() < 1; w++) step();
        repeat (8) step();
        check("t6.n_valid0", v_res.size(), 1);
        check("t6.n_issue0", i_cyc.size(), 1);
        check("t6.busy_pause", oBUSY, 1);
        check("t6.pc_pause", oPC, 0);
        iSTEP = 1'b1;
        step();
        iSTEP = 1'b0;
        for (int w = 0; w < 40 && v_res.size() < 2; w++) step();
        repeat (8) step();
        check("t6.n_issue1", i_cyc.size(), 2);
        check("t6.pc_pause1", oPC, 1);
        iSTEP = 1'b1;
        step();
        iSTEP = 1'b0;
        for (int w = 0; w < 40 && d_cnt == 0; w++) step();
        check("t6.done", d_cnt, 1);
        check("t6.n_valid", v_res.size(), 2);
        if (v_res.size() == 2) begin
            check("t6.res0", v_res[0], 8'h12);
            check("t6.res1", v_res[1], 8'h23);
        end
        check("t6.pc_final", oPC, 2);
        iSTEP_MODE = 1'b0;
        step();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
